// File: rtl/mem_pkg.sv
// mem_pkg: shared types, defaults and the address screen for the RAM port-2 arbiter.
package mem_pkg;
  localparam int unsigned MEM_BYTES_DEF = 1024;
  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] mem_bytes = 32'(MEM_BYTES_DEF));
    return addr[1:0] == 2'b00 && addr <= mem_bytes - 32'd4;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the mask restricts candidates to the lock owner.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic [1:0] i_mask,
  output logic [1:0] o_grant
);
  logic [1:0] w_req;
  assign w_req   = i_req & i_mask;
  assign o_grant = w_req[i_ptr]  ? (i_ptr ? 2'b10 : 2'b01) :
                   w_req[~i_ptr] ? (i_ptr ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares RAM port 2 between two requesters with round-robin, lock and address screening.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned NREQ      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_err,
  output logic [31:0]          rsp_rdata,
  output logic                 mem_wen,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);
  arb_state_e  r_state, w_state_nxt;
  logic        r_ptr, w_ptr_nxt, r_owner, w_owner_nxt;
  logic [1:0]  w_mask, w_grant, r_rsp_valid;
  logic        w_acc, w_gsel, w_legal, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  mem_req_t    w_req;
  assign w_mask = (r_state == LOCKED) ? (r_owner ? 2'b10 : 2'b01) : 2'b11;
  // Nothing is granted while reset is held, so no RAM write can slip through.
  rr_arbiter2 u_arb (
    .i_req  (req_valid & {2{~rst}}),
    .i_ptr  (r_ptr),
    .i_mask (w_mask),
    .o_grant(w_grant)
  );
  assign w_acc   = |w_grant;
  assign w_gsel  = w_grant[1];
  assign w_req   = '{we: req_we[w_gsel], lock: req_lock[w_gsel], addr: req_addr[w_gsel], wdata: req_wdata[w_gsel]};
  assign w_legal = addr_legal(w_req.addr, 32'(MEM_BYTES));
  assign req_ready = w_grant;
  assign mem_wen   = w_acc & w_req.we & w_legal;
  assign mem_addr  = (w_acc & w_legal) ? w_req.addr : '0;
  assign mem_wdata = w_acc ? w_req.wdata : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  // The pointer rotates only on beats accepted in IDLE; it is frozen while locked.
  always_comb begin
    w_ptr_nxt   = (w_acc && r_state == IDLE) ? ~w_gsel : r_ptr;
    w_state_nxt = w_acc ? (w_req.lock ? LOCKED : IDLE) : r_state;
    w_owner_nxt = w_acc ? w_gsel : r_owner;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_rsp_valid <= w_grant;
      r_rsp_err   <= w_acc & ~w_legal;
      r_rsp_rdata <= (w_acc & w_legal & ~w_req.we) ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a behavioural arbiter and memory model.
module tb_mem_port_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [1:0][31:0] req_addr, req_wdata;
  logic             rsp_err, mem_wen;
  logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]       ram [0:1023];
  logic [31:0]      m_mem [0:255];
  int               m_ptr, m_owner;
  logic [1:0]       e_rv;
  logic             e_err;
  logic [31:0]      e_rd;
  int               n_tests = 0, n_fail = 0;

  mem_port_arbiter #(.MEM_BYTES(1024), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte-addressed little-endian RAM: combinational read, write on the clock edge.
  assign mem_rdata = {ram[mem_addr[9:0] + 10'd3], ram[mem_addr[9:0] + 10'd2],
                      ram[mem_addr[9:0] + 10'd1], ram[mem_addr[9:0]]};
  always @(posedge clk) if (mem_wen) begin
    ram[mem_addr[9:0]]         <= mem_wdata[7:0];
    ram[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
    ram[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
    ram[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input bit v, input bit we, input bit lk, input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk; req_addr[i] = a; req_wdata[i] = d;
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  // One clock: predict grant and port drive from the rules, compare, then advance the model.
  task automatic cycle();
    int          g;
    logic [31:0] a, wd;
    logic        we, lk, legal;
    logic [1:0]  e_rdy;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (m_owner >= 0) g = req_valid[m_owner] ? m_owner : -1;
      else if (req_valid[m_ptr]) g = m_ptr;
      else if (req_valid[1 - m_ptr]) g = 1 - m_ptr;
    end
    e_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
    a = (g < 0) ? 32'd0 : req_addr[g];
    wd = (g < 0) ? 32'd0 : req_wdata[g];
    we = (g < 0) ? 1'b0 : req_we[g];
    lk = (g < 0) ? 1'b0 : req_lock[g];
    legal = (a % 4 == 0) && (a <= 32'd1020);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mem_wen", 32'(mem_wen), 32'(g >= 0 && legal && we));
    chk("mem_addr", mem_addr, (g >= 0 && legal) ? a : 32'd0);
    chk("mem_wdata", mem_wdata, wd);
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_rdata", rsp_rdata, e_rd);
    if (rst) begin
      m_ptr = 0; m_owner = -1; e_rv = 0; e_err = 0; e_rd = 0;
    end else begin
      e_rv  = e_rdy;
      e_err = (g >= 0) && !legal;
      e_rd  = (g >= 0 && legal && !we) ? m_mem[a >> 2] : 32'd0;
      if (g >= 0 && legal && we) m_mem[a >> 2] = wd;
      if (g >= 0) begin
        if (m_owner < 0) m_ptr = 1 - g;
        m_owner = lk ? g : -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    return (k == 0) ? 32'($urandom) : (k == 1) ? 32'($urandom_range(1016, 1032)) : 32'($urandom_range(0, 31) << 2);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = $urandom;
      {ram[4*i+3], ram[4*i+2], ram[4*i+1], ram[4*i]} = m_mem[i];
    end
    m_ptr = 0; m_owner = -1; e_rv = 0; e_err = 0; e_rd = 0;
    rst = 1'b1;
    idle_all();
    repeat (2) cycle();
    rst = 1'b0;
    // Both requesters reading continuously: grants alternate 0,1,0,1.
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h20, 0);
    repeat (6) cycle();
    idle_all();
    cycle();
    // Write then read back on consecutive beats.
    drive(0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
    cycle();
    drive(0, 1, 0, 0, 32'h40, 0);
    cycle();
    idle_all();
    cycle();
    chk("ram_40", {ram[67], ram[66], ram[65], ram[64]}, 32'hDEADBEEF);
    // Requester 1 locks for three beats while requester 0 waits.
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 1, 1, 32'h100, 32'h11111111);
    cycle();
    drive(1, 1, 1, 1, 32'h104, 32'h22222222);
    cycle();
    drive(1, 1, 0, 0, 32'h100, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    idle_all();
    cycle();
    // Misaligned and out-of-range beats, then the top legal word.
    drive(0, 1, 0, 0, 32'h42, 0);
    cycle();
    drive(0, 1, 1, 0, 32'd1024, 32'hBADBAD00);
    cycle();
    drive(0, 1, 1, 0, 32'h3FC, 32'hCAFEF00D);
    cycle();
    drive(0, 1, 0, 0, 32'h3FC, 0);
    cycle();
    idle_all();
    cycle();
    // Reset during a write and during a lock.
    drive(1, 1, 1, 0, 32'h80, 32'h12345678);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle_all();
    cycle();
    drive(0, 1, 0, 1, 32'h10, 0);
    cycle();
    drive(1, 1, 0, 0, 32'h20, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 1, 0, 0, 32'h14, 0);
    repeat (3) cycle();
    idle_all();
    repeat (10) cycle();
    // Random traffic with occasional resets.
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rand_addr(), $urandom);
      rst = ($urandom_range(0, 40) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_all();
    cycle();
    for (int i = 0; i < 256; i++)
      chk("ram_final", {ram[4*i+3], ram[4*i+2], ram[4*i+1], ram[4*i]}, m_mem[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
